result_store_writer: RTL and testbench

- Writer side of the matrix data buffers: accepts one group of four 16-bit result words in parallel and serializes them into a single-port DRAM.
- Writes one word per clock to consecutive addresses.
- Sits between the MAC array outputs and the result DRAM.
- Drives the same address/data/wren RAM port shape the operand buffers read from, so results can be read back as four-word groups.

---
 rtl/result_store_writer_if.sv | 27 ++
 rtl/result_store_writer.sv | 120 ++++++++++++
 tb/tb_result_store_writer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/result_store_writer_if.sv
// Result-writer bus: four-lane group handshake in, single-port DRAM write port out.
interface result_store_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [DATA_W-1:0] data4;
  logic [ADDR_W-1:0] dram_address;
  logic [DATA_W-1:0] dram_data;
  logic              dram_wren;
  logic              busy;
  logic              done;

  modport slave (
    input  in_valid, data1, data2, data3, data4,
    output in_ready, dram_address, dram_data, dram_wren, busy, done
  );

  modport master (
    output in_valid, data1, data2, data3, data4,
    input  in_ready, dram_address, dram_data, dram_wren, busy, done
  );
endinterface

// File: rtl/result_store_writer.sv
// Serializes four-word result groups into consecutive DRAM addresses, one word per clock.
module result_store_writer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_GROUPS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  result_store_writer_if.slave bus
);
  localparam int                LANES = 4;
  localparam int                CNT_W = $clog2(NUM_GROUPS + 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     lane_q, lane_d;
  logic [ADDR_W-1:0]              ptr_q, ptr_d, addr_q, addr_d, grp_ptr;
  logic [CNT_W-1:0]               gcnt_q, gcnt_d;
  logic [LANES-1:0][DATA_W-1:0]   hold_q, hold_d, lanes_in;
  logic [DATA_W-1:0]              wdata_q, wdata_d;
  logic                           wren_q, wren_d, done_q, done_d;
  logic                           accept, load;

  // lane index 0 carries data1, which lands at the lowest address
  assign lanes_in     = {bus.data4, bus.data3, bus.data2, bus.data1};
  assign bus.in_ready = rst_n && !start &&
                        ((state_q == IDLE) || (state_q == WRITE && lane_q == 2'd3));
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.dram_address = addr_q;
  assign bus.dram_data    = wdata_q;
  assign bus.dram_wren    = wren_q;
  assign bus.busy         = wren_q;
  assign bus.done         = done_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    gcnt_d  = gcnt_q;
    hold_d  = hold_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    grp_ptr = ptr_q;
    load    = 1'b0;

    if (start) begin
      state_d = IDLE;
      lane_d  = 2'd0;
      ptr_d   = BASE;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: load = accept;
        WRITE: begin
          if (lane_q != 2'd3) begin
            lane_d  = lane_q + 2'd1;
            wren_d  = 1'b1;
            addr_d  = ptr_q;
            wdata_d = hold_q[lane_q + 2'd1];
            ptr_d   = ptr_q + 1'b1;
          end else begin
            // lane-4 word is on the bus this cycle: close out the group
            if (gcnt_q == CNT_W'(NUM_GROUPS - 1)) begin
              done_d  = 1'b1;
              gcnt_d  = '0;
              grp_ptr = BASE;
            end else begin
              gcnt_d  = gcnt_q + 1'b1;
            end
            ptr_d   = grp_ptr;
            load    = accept;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        hold_d  = lanes_in;
        wren_d  = 1'b1;
        addr_d  = grp_ptr;
        wdata_d = bus.data1;
        ptr_d   = grp_ptr + 1'b1;
        lane_d  = 2'd0;
        state_d = WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      ptr_q   <= BASE;
      addr_q  <= BASE;
      gcnt_q  <= '0;
      hold_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      gcnt_q  <= gcnt_d;
      hold_q  <= hold_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_result_store_writer.sv
// Scoreboard bench: dut_a uses default parameters, dut_b a 4-bit address space at base 14 with 2-group matrices.
module tb_result_store_writer;
  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;

  always #5 clk = ~clk;

  result_store_writer_if #(.DATA_W(16), .ADDR_W(8)) bus_a ();
  result_store_writer_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

  result_store_writer #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(0), .NUM_GROUPS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a.slave));
  result_store_writer #(.DATA_W(16), .ADDR_W(4), .BASE_ADDR(14), .NUM_GROUPS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b.slave));

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    bit          dn;
  } item_t;

  item_t qa[$];
  item_t qb[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    pend_a = 1'b0;
  bit    pend_b = 1'b0;

  function automatic void chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // monitors: every write must match the head of the expected queue
  always @(negedge clk) begin
    item_t it;
    bit    nd;
    nd = 1'b0;
    if (bus_a.dram_wren) begin
      if (qa.size() == 0) chk("a_unexpected_write", 1, 0);
      else begin
        it = qa.pop_front();
        chk("a_addr", bus_a.dram_address, it.addr);
        chk("a_data", bus_a.dram_data, it.data);
        nd = it.dn;
      end
    end
    if (bus_a.done || pend_a) chk("a_done", bus_a.done, pend_a);
    if (bus_a.busy || bus_a.dram_wren) chk("a_busy", bus_a.busy, bus_a.dram_wren);
    pend_a = nd;
  end

  always @(negedge clk) begin
    item_t it;
    bit    nd;
    nd = 1'b0;
    if (bus_b.dram_wren) begin
      if (qb.size() == 0) chk("b_unexpected_write", 1, 0);
      else begin
        it = qb.pop_front();
        chk("b_addr", bus_b.dram_address, it.addr);
        chk("b_data", bus_b.dram_data, it.data);
        nd = it.dn;
      end
    end
    if (bus_b.done || pend_b) chk("b_done", bus_b.done, pend_b);
    if (bus_b.busy || bus_b.dram_wren) chk("b_busy", bus_b.busy, bus_b.dram_wren);
    pend_b = nd;
  end

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) bus_a.in_valid = v;
    else          bus_b.in_valid = v;
  endtask

  // drive a group, wait for acceptance, queue the nw words expected to be written
  task automatic send(input int sel, input int addr, input logic [15:0] d1, d2, d3, d4,
                      input int nw, input bit dn, output int waits);
    logic [15:0] d[4];
    logic        rdy;
    item_t       it;
    int          mask;
    d     = '{d1, d2, d3, d4};
    mask  = (sel == 0) ? 255 : 15;
    waits = 0;
    @(negedge clk);
    if (sel == 0) begin
      bus_a.in_valid = 1'b1;
      bus_a.data1 = d1; bus_a.data2 = d2; bus_a.data3 = d3; bus_a.data4 = d4;
      rdy = bus_a.in_ready;
    end else begin
      bus_b.in_valid = 1'b1;
      bus_b.data1 = d1; bus_b.data2 = d2; bus_b.data3 = d3; bus_b.data4 = d4;
      rdy = bus_b.in_ready;
    end
    while (!rdy && waits < 20) begin
      @(negedge clk);
      waits++;
      rdy = (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
    end
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < nw; i++) begin
      it.addr = 8'((addr + i) & mask);
      it.data = d[i];
      it.dn   = dn && (i == 3);
      if (sel == 0) qa.push_back(it);
      else          qb.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, n;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.data1 = '0; bus_a.data2 = '0; bus_a.data3 = '0; bus_a.data4 = '0;
    bus_b.in_valid = 1'b0; bus_b.data1 = '0; bus_b.data2 = '0; bus_b.data3 = '0; bus_b.data4 = '0;
    #12;
    chk("rst_wren", bus_a.dram_wren, 0);
    chk("rst_addr", bus_a.dram_address, 0);
    chk("rst_data", bus_a.dram_data, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_ready", bus_a.in_ready, 0);
    chk("rst_addr_b", bus_b.dram_address, 14);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("post_rst_ready", bus_a.in_ready, 1);

    // single group, in_ready returns in the last write cycle
    send(0, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 4, 1'b0, w);
    set_valid(0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_a.in_ready && n < 10);
    chk("t1_ready_latency", n, 4);
    repeat (3) @(negedge clk);
    chk("t1_idle_wren", bus_a.dram_wren, 0);
    chk("t1_idle_data_held", bus_a.dram_data, 16'h0044);

    // start while idle, then three groups back to back
    @(negedge clk); start_a = 1'b1; bus_a.in_valid = 1'b1;
    #1 chk("t2_ready_during_start", bus_a.in_ready, 0);
    @(negedge clk); start_a = 1'b0; bus_a.in_valid = 1'b0;
    send(0, 0, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 4, 1'b0, w);
    send(0, 4, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 4, 1'b0, w);
    chk("t2_gap_g2", w, 3);
    send(0, 8, 16'h3001, 16'h3002, 16'h3003, 16'h3004, 4, 1'b0, w);
    chk("t2_gap_g3", w, 3);
    set_valid(0, 1'b0);
    repeat (6) @(negedge clk);

    // start in the second write cycle aborts the group
    send(0, 12, 16'h4001, 16'h4002, 16'h4003, 16'h4004, 2, 1'b0, w);
    set_valid(0, 1'b0);
    @(negedge clk);
    @(negedge clk); start_a = 1'b1; bus_a.in_valid = 1'b1;
    #1 chk("t5_ready_during_start", bus_a.in_ready, 0);
    @(negedge clk); start_a = 1'b0; bus_a.in_valid = 1'b0;
    chk("t5_wren_after_start", bus_a.dram_wren, 0);
    repeat (2) @(negedge clk);
    send(0, 0, 16'h5001, 16'h5002, 16'h5003, 16'h5004, 4, 1'b0, w);
    set_valid(0, 1'b0);
    repeat (6) @(negedge clk);

    // asynchronous reset during the third write
    send(0, 4, 16'h6001, 16'h6002, 16'h6003, 16'h6004, 3, 1'b0, w);
    set_valid(0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_wren", bus_a.dram_wren, 0);
    chk("t6_async_busy", bus_a.busy, 0);
    chk("t6_async_ready", bus_a.in_ready, 0);
    chk("t6_async_addr", bus_a.dram_address, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after_rst", bus_a.in_ready, 1);
    send(0, 0, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 4, 1'b0, w);
    set_valid(0, 1'b0);
    repeat (6) @(negedge clk);

    // dut_b: address wrap 14,15,0,1
    send(1, 14, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 4, 1'b0, w);
    set_valid(1, 1'b0);
    repeat (6) @(negedge clk);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;

    // dut_b: two-group matrices back to back, pointer returns to base after done
    send(1, 14, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 4, 1'b0, w);
    send(1, 2,  16'hB101, 16'hB102, 16'hB103, 16'hB104, 4, 1'b1, w);
    send(1, 14, 16'hB201, 16'hB202, 16'hB203, 16'hB204, 4, 1'b0, w);
    chk("t3_gap_after_done", w, 3);
    send(1, 2,  16'hB301, 16'hB302, 16'hB303, 16'hB304, 4, 1'b1, w);
    set_valid(1, 1'b0);
    repeat (8) @(negedge clk);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
